a2d_spi_resp: RTL and testbench
===============================

Name: a2d_spi_resp

Overview:
Synthesizable SPI responder that acts as the far end of the segway's A2D SPI link, emulating the ADC128S-style 8-channel converter protocol. It receives 16-bit command frames from the segway A2D initiator on MOSI and returns 12-bit channel samples on MISO. Channels carry load cells, steer pot and battery. It replaces the behavioural converter model in FPGA bring-up and hardware-in-loop rigs, with channel values supplied by a host or register block.

Parameters:
SYNC_STAGES, 2, flops in each SS_n/SCLK/MOSI input synchronizer (legal values 2..3).
RST_CHAN, 0, channel that is addressed after reset (0..7).

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active high
SS_n  in  1  SPI select from initiator, active low
SCLK  in  1  SPI clock from initiator (mode 0)
MOSI  in  1  SPI data from initiator
MISO  out  1  SPI data to initiator
ch_data  in  96  eight 12-bit channel values; ch N is at [12N+11:12N]
cmd  out  16  last complete command frame received
chan  out  3  channel currently addressed, equal to cmd[13:11] of the last complete frame
frame_done  out  1  one-clk pulse at the end of each complete 16-bit frame
frame_err  out  1  one-clk pulse when SS_n rises before 16 SCLK rises

Behaviour:
- Reset (async, rst=1): state IDLE; cmd=0; chan=RST_CHAN; MISO=0; frame_done=0; frame_err=0; shift registers and bit_cnt cleared.
- Inputs: SS_n, SCLK and MOSI each pass through a SYNC_STAGES flop chain. Edges are detected on the synchronized SS_n and SCLK. Input-to-action latency is SYNC_STAGES+1 clk.
- Timing requirement: SCLK high and low phases each ≥ 2*(SYNC_STAGES+1) clk. SS_n setup to first SCLK rise is also ≥ 2*(SYNC_STAGES+1) clk.
- SPI mode 0. MOSI is sampled on the synchronized SCLK rise and shifted MSB-first into rx_shft[15:0]. MISO is taken from tx_shft[15] and shifts left on the synchronized SCLK fall.
- State IDLE:
  - On SS_n fall: load tx_shft = {4'b0000, ch_data[chan]}, snapshotted in that clk; clear bit_cnt; go to SHIFT.
  - MISO = 0.
- State SHIFT:
  - Each SCLK rise: bit_cnt++.
  - Each SCLK fall with bit_cnt ≥ 1: tx_shft shifts left, zero-filled.
  - SCLK fall while bit_cnt==0 is ignored, so the initiator's idle-low SCLK causes no shift.
  - When bit_cnt reaches 16: go to DONE.
- State DONE:
  - Waits for SS_n rise. Further SCLK edges are ignored and MISO holds 0.
  - On SS_n rise: cmd ← rx_shft; chan ← rx_shft[13:11]; frame_done=1 for one clk; go to IDLE.
- Abort: SS_n rise while in SHIFT (fewer than 16 rises). frame_err=1 for one clk; cmd and chan are unchanged; go to IDLE.
- Pipelined addressing: the data returned in frame N is the channel addressed by frame N-1. The first frame after reset returns ch RST_CHAN.
- ch_data changes mid-frame do not affect the frame in progress, because the value is snapshotted at SS_n fall.
- SS_n fall and rise within the same synchronized clk are not possible, since SS_n passes through a single synchronizer. A glitch shorter than one clk may be missed entirely, which is acceptable.
- An SS_n fall detected in the same clk as a frame_done/frame_err is handled in IDLE on the next clk. No frame is lost as long as SS_n high ≥ SYNC_STAGES+2 clk.
- Reset asserted mid-frame: immediate return to IDLE with reset values. The frame is discarded and no pulses are produced.
- cmd bits other than [13:11] are stored in cmd but otherwise ignored.

Test Plan:
- Post-reset read: ch0=0x300, SCLK period 32 clk, 16-bit frame with MOSI=0x0000. MISO returns 0x0300. frame_done pulses once; chan=0.
- Channel pipelining: set ch2=0xE00 (steer pot). Send frame with MOSI=0x1000 (chan 2), MISO returns the old channel. Next frame returns 0x0E00; chan=2.
- Sweep: address each channel 0..7, with ch N = 0x111*N+0x100, using back-to-back frames with SS_n high 4 clk. Every response matches the value addressed by the previous frame; 8 frame_done pulses.
- Abort: raise SS_n after 9 SCLK rises of MOSI=0x3800. Expect a frame_err pulse, no frame_done, and chan unchanged. The following frame still returns the previous channel's value.
- Snapshot: change ch2 from 0xA00 to 0x200 after SCLK rise 3 of a read of ch2. MISO returns 0x0A00; the next read returns 0x0200.
- Reset mid-frame: assert rst after SCLK rise 7. Outputs return to reset values; no pulses occur; the next full frame returns ch RST_CHAN.

Source files
------------

// File: rtl/a2d_spi_resp.sv
// rtl/a2d_spi_resp.sv - SPI responder emulating an 8-channel 12-bit A2D converter
// Receives 16-bit command frames, returns the channel addressed by the previous frame.
module a2d_spi_resp #(
   parameter int SYNC_STAGES = 2,
   parameter int RST_CHAN    = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        SS_n,
   input  logic        SCLK,
   input  logic        MOSI,
   output logic        MISO,
   input  logic [95:0] ch_data,
   output logic [15:0] cmd,
   output logic [2:0]  chan,
   output logic        frame_done,
   output logic        frame_err
);

   localparam logic [2:0] RST_CHAN_L = 3'(RST_CHAN);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t state, next_state;

   logic [SYNC_STAGES-1:0] ss_sync;
   logic [SYNC_STAGES-1:0] sclk_sync;
   logic [SYNC_STAGES-1:0] mosi_sync;
   logic                   ss_prev;
   logic                   sclk_prev;
   logic                   ss_s;
   logic                   sclk_s;
   logic                   mosi_s;

   logic                   ss_fall;
   logic                   ss_rise;
   logic                   sclk_rise;
   logic                   sclk_fall;

   logic [15:0]            rx_shft;
   logic [15:0]            tx_shft;
   logic [4:0]             bit_cnt;
   logic [11:0]            ch_sel;

   logic                   load_tx;
   logic                   sample_rx;
   logic                   shift_tx;
   logic                   done_set;
   logic                   err_set;

   // SS_n resets high so that leaving reset never looks like a select edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ss_sync   <= '1;
         sclk_sync <= '0;
         mosi_sync <= '0;
         ss_prev   <= 1'b1;
         sclk_prev <= 1'b0;
      end else begin
         ss_sync   <= {ss_sync[SYNC_STAGES-2:0], SS_n};
         sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
         ss_prev   <= ss_s;
         sclk_prev <= sclk_s;
      end
   end

   assign ss_s      = ss_sync[SYNC_STAGES-1];
   assign sclk_s    = sclk_sync[SYNC_STAGES-1];
   assign mosi_s    = mosi_sync[SYNC_STAGES-1];

   assign ss_fall   = ss_prev & ~ss_s;
   assign ss_rise   = ~ss_prev & ss_s;
   assign sclk_rise = ~sclk_prev & sclk_s;
   assign sclk_fall = sclk_prev & ~sclk_s;

   assign ch_sel    = ch_data[12*int'(chan) +: 12];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      load_tx    = 1'b0;
      sample_rx  = 1'b0;
      shift_tx   = 1'b0;
      done_set   = 1'b0;
      err_set    = 1'b0;
      case (state)
         IDLE: begin
            if (ss_fall) begin
               load_tx    = 1'b1;
               next_state = SHIFT;
            end
         end
         SHIFT: begin
            if (ss_rise) begin
               err_set    = 1'b1;
               next_state = IDLE;
            end else begin
               if (sclk_rise) begin
                  sample_rx = 1'b1;
                  if (bit_cnt == 5'd15) begin
                     next_state = DONE;
                  end
               end
               // The idle-low SCLK before the first rise must not shift out bit 15.
               if (sclk_fall && (bit_cnt != 5'd0)) begin
                  shift_tx = 1'b1;
               end
            end
         end
         DONE: begin
            if (ss_rise) begin
               done_set   = 1'b1;
               next_state = IDLE;
            end
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_shft    <= '0;
         tx_shft    <= '0;
         bit_cnt    <= '0;
         cmd        <= '0;
         chan       <= RST_CHAN_L;
         frame_done <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         frame_done <= done_set;
         frame_err  <= err_set;
         if (load_tx) begin
            tx_shft <= {4'b0000, ch_sel};
            bit_cnt <= '0;
         end else if (shift_tx) begin
            tx_shft <= {tx_shft[14:0], 1'b0};
         end
         if (sample_rx) begin
            rx_shft <= {rx_shft[14:0], mosi_s};
            bit_cnt <= bit_cnt + 5'd1;
         end
         if (done_set) begin
            cmd  <= rx_shft;
            chan <= rx_shft[13:11];
         end
      end
   end

   assign MISO = (state == SHIFT) ? tx_shft[15] : 1'b0;

endmodule

// File: tb/tb_a2d_spi_resp.sv
// tb/tb_a2d_spi_resp.sv - directed scoreboard bench for a2d_spi_resp
// Drives mode-0 SPI frames and checks MISO words, cmd/chan and pulse counts.
module tb_a2d_spi_resp;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        SS_n = 1'b1;
   logic        SCLK = 1'b0;
   logic        MOSI = 1'b0;
   logic        MISO;
   logic [95:0] ch_data = '0;
   logic [15:0] cmd;
   logic [2:0]  chan;
   logic        frame_done;
   logic        frame_err;

   int          total = 0;
   int          bad = 0;
   int          done_cnt = 0;
   int          err_cnt = 0;

   logic [15:0] exp_q[$];
   logic [2:0]  model_chan = 3'd0;
   logic [15:0] model_cmd = 16'h0000;

   a2d_spi_resp #(.SYNC_STAGES(2), .RST_CHAN(0)) dut (
      .clk        (clk),
      .rst        (rst),
      .SS_n       (SS_n),
      .SCLK       (SCLK),
      .MOSI       (MOSI),
      .MISO       (MISO),
      .ch_data    (ch_data),
      .cmd        (cmd),
      .chan       (chan),
      .frame_done (frame_done),
      .frame_err  (frame_err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (frame_done === 1'b1) done_cnt++;
      if (frame_err === 1'b1) err_cnt++;
   end

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_ch(input int n, input logic [11:0] v);
      ch_data[12*n +: 12] = v;
   endtask

   function automatic logic [15:0] ch_word(input logic [2:0] c);
      logic [11:0] v;
      v = ch_data[12*int'(c) +: 12];
      return {4'b0000, v};
   endfunction

   // nrise < 16 aborts; rst_mid asserts reset after nrise rises; chg_at changes ch2 after that rise.
   task automatic run_frame(input string tag, input logic [15:0] w, input int nrise,
                            input int gap, input int chg_at, input logic [11:0] chg_val,
                            input bit rst_mid);
      logic [15:0] miso_word;
      logic [15:0] exp;
      logic [15:0] mask;
      miso_word = '0;
      if (!rst_mid) exp_q.push_back(ch_word(model_chan));
      SS_n = 1'b0;
      MOSI = w[15];
      wait_clk(16);
      for (int i = 0; i < nrise; i++) begin
         MOSI = w[15-i];
         wait_clk(16);
         miso_word[15-i] = MISO;
         SCLK = 1'b1;
         if (i + 1 == chg_at) set_ch(2, chg_val);
         wait_clk(16);
         SCLK = 1'b0;
      end
      if (rst_mid) begin
         rst = 1'b1;
         wait_clk(2);
         check({tag, "_rst_cmd"}, 32'(cmd), 32'h0);
         check({tag, "_rst_chan"}, 32'(chan), 32'h0);
         check({tag, "_rst_miso"}, 32'(MISO), 32'h0);
         check({tag, "_rst_pulses"}, 32'({frame_done, frame_err}), 32'h0);
         SS_n = 1'b1;
         wait_clk(8);
         rst = 1'b0;
         model_chan = 3'd0;
         model_cmd  = 16'h0000;
         wait_clk(gap);
      end else begin
         wait_clk(16);
         SS_n = 1'b1;
         wait_clk(gap);
         exp = exp_q.pop_front();
         mask = 16'hFFFF << (16 - nrise);
         check({tag, "_miso"}, 32'(miso_word & mask), 32'(exp & mask));
         if (nrise == 16) begin
            model_chan = w[13:11];
            model_cmd  = w;
         end
      end
   endtask

   initial begin
      int d0;
      int e0;
      logic [15:0] w;

      set_ch(0, 12'h300);
      wait_clk(4);
      check("reset_cmd", 32'(cmd), 32'h0);
      check("reset_chan", 32'(chan), 32'h0);
      check("reset_miso", 32'(MISO), 32'h0);
      check("reset_pulses", 32'({frame_done, frame_err}), 32'h0);
      rst = 1'b0;
      wait_clk(4);

      // post-reset read of channel 0
      d0 = done_cnt; e0 = err_cnt;
      run_frame("first", 16'h0000, 16, 12, 0, 12'h0, 1'b0);
      check("first_done", 32'(done_cnt - d0), 32'd1);
      check("first_chan", 32'(chan), 32'(model_chan));

      // pipelined addressing
      set_ch(2, 12'hE00);
      run_frame("pipe_a", 16'h1000, 16, 12, 0, 12'h0, 1'b0);
      check("pipe_a_chan", 32'(chan), 32'd2);
      check("pipe_a_cmd", 32'(cmd), 32'h1000);
      run_frame("pipe_b", 16'h1000, 16, 12, 0, 12'h0, 1'b0);

      // sweep with back-to-back frames and random don't-care command bits
      for (int n = 0; n < 8; n++) set_ch(n, 12'(12'h111 * n + 12'h100));
      d0 = done_cnt; e0 = err_cnt;
      for (int n = 0; n < 8; n++) begin
         w = (16'($urandom) & 16'hC7FF) | 16'(n << 11);
         run_frame($sformatf("sweep%0d", n), w, 16, 4, 0, 12'h0, 1'b0);
      end
      wait_clk(12);
      check("sweep_done", 32'(done_cnt - d0), 32'd8);
      check("sweep_err", 32'(err_cnt - e0), 32'd0);
      check("sweep_chan", 32'(chan), 32'd7);
      check("sweep_cmd", 32'(cmd), 32'(model_cmd));

      // abort after 9 rises
      d0 = done_cnt; e0 = err_cnt;
      run_frame("abort", 16'h3800, 9, 12, 0, 12'h0, 1'b0);
      check("abort_err", 32'(err_cnt - e0), 32'd1);
      check("abort_done", 32'(done_cnt - d0), 32'd0);
      check("abort_chan", 32'(chan), 32'd7);
      check("abort_cmd", 32'(cmd), 32'(model_cmd));
      run_frame("post_abort", 16'h1000, 16, 12, 0, 12'h0, 1'b0);

      // snapshot at SS_n fall protects the frame in flight
      set_ch(2, 12'hA00);
      run_frame("snap_a", 16'h1000, 16, 12, 3, 12'h200, 1'b0);
      run_frame("snap_b", 16'h1000, 16, 12, 0, 12'h0, 1'b0);

      // reset mid-frame
      d0 = done_cnt; e0 = err_cnt;
      run_frame("midrst", 16'h2800, 7, 12, 0, 12'h0, 1'b1);
      check("midrst_pulses", 32'((done_cnt - d0) + (err_cnt - e0)), 32'd0);
      check("midrst_chan", 32'(chan), 32'd0);
      run_frame("after_rst", 16'h2800, 16, 12, 0, 12'h0, 1'b0);
      check("after_rst_chan", 32'(chan), 32'd5);
      check("queue_empty", 32'(exp_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
